// File: rtl/ball_motion.sv
// ball_motion: steps NUM_BALLS bouncing balls, one ball per cycle, once per v_sync falling edge.
module ball_motion #(
  parameter int NUM_BALLS     = 4,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_DIM      = 25,
  parameter int BALL_SPEED    = 5
) (
  input  logic                    clk_100mhz,
  input  logic                    reset,
  input  logic                    v_sync,
  input  logic                    freeze,
  output logic [10*NUM_BALLS-1:0] ball_x,
  output logic [10*NUM_BALLS-1:0] ball_y,
  output logic                    busy,
  output logic                    frame_tick,
  output logic                    missed_frame
);
  localparam logic [10:0] XMAX = 11'(SCREEN_WIDTH - BALL_DIM);
  localparam logic [10:0] YMAX = 11'(SCREEN_HEIGHT - BALL_DIM);
  typedef enum logic {IDLE, UPDATE} state_t;
  state_t r_state, w_state_n;
  logic [1:0] r_idx, w_idx_n;
  logic r_vsync_d, r_arm, r_tick, r_missed, w_edge, w_last, w_upd;
  logic [9:0] r_x [NUM_BALLS];
  logic [9:0] r_y [NUM_BALLS];
  logic [NUM_BALLS-1:0] r_vx, r_vy;
  // returns {direction, position}; 11-bit sums keep p+s from wrapping
  function automatic logic [10:0] step(input logic [9:0] p, input logic d,
                                       input logic [10:0] s, input logic [10:0] m);
    logic [10:0] sum, dif;
    sum = {1'b0, p} + s;
    dif = {1'b0, p} - s;
    if (d) return (sum >= m) ? {1'b0, 10'(m)} : {1'b1, 10'(sum)};
    return ({1'b0, p} <= s) ? {1'b1, 10'd0} : {1'b0, 10'(dif)};
  endfunction
  // r_arm masks the first cycle after reset so v_sync held low through release is not an edge
  assign w_edge = r_vsync_d & ~v_sync & r_arm;
  assign w_last = (r_state == UPDATE) && (r_idx == 2'(NUM_BALLS - 1));
  assign w_upd  = (r_state == UPDATE) && !freeze;
  always_comb begin
    w_state_n = (r_state == IDLE) ? (w_edge ? UPDATE : IDLE) : (w_last ? IDLE : UPDATE);
    w_idx_n   = (r_state == UPDATE && !w_last) ? r_idx + 2'd1 : 2'd0;
  end
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_vsync_d <= 1'b1;
      r_arm     <= 1'b0;
      r_tick    <= 1'b0;
      r_missed  <= 1'b0;
      for (int k = 0; k < NUM_BALLS; k++) begin
        r_x[k]  <= 10'(40 + 150 * k);
        r_y[k]  <= 10'(30 + 100 * k);
        r_vx[k] <= (k % 2 == 0);
        r_vy[k] <= 1'b1;
      end
    end else begin
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_vsync_d <= v_sync;
      r_arm     <= 1'b1;
      r_tick    <= w_last;
      r_missed  <= r_missed | (w_edge & busy);
      for (int k = 0; k < NUM_BALLS; k++)
        if (w_upd && r_idx == 2'(k)) begin
          {r_vx[k], r_x[k]} <= step(r_x[k], r_vx[k], 11'(BALL_SPEED + k), XMAX);
          {r_vy[k], r_y[k]} <= step(r_y[k], r_vy[k], 11'(BALL_SPEED + k), YMAX);
        end
    end
  end
  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_pack
    assign ball_x[10*g +: 10] = r_x[g];
    assign ball_y[10*g +: 10] = r_y[g];
  end
  assign busy         = (r_state == UPDATE);
  assign frame_tick   = r_tick;
  assign missed_frame = r_missed;
endmodule
